// File: rtl/handshake_rr_merge.sv
// Three-to-one round-robin merge with a single registered output beat.
// Each output beat is tagged with its source channel, and a wrapping counter tracks completed output transfers.
module handshake_rr_merge #(
  parameter int WIDTH     = 5,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 handshake_arr_0_valid,
  output logic                 handshake_arr_0_ready,
  input  logic [WIDTH-1:0]     data_0,
  input  logic                 handshake_arr_1_valid,
  output logic                 handshake_arr_1_ready,
  input  logic [WIDTH-1:0]     data_1,
  input  logic                 handshake_arr_2_valid,
  output logic                 handshake_arr_2_ready,
  input  logic [WIDTH-1:0]     data_2,
  output logic                 handshake_valid,
  input  logic                 handshake_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_src,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  logic [2:0]       in_valid;
  logic [2:0]       in_ready;
  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic [1:0]       ptr_next;
  logic [WIDTH-1:0] grant_data;
  logic             any_valid;
  logic             load_en;

  assign in_valid  = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};
  assign any_valid = |in_valid;
  assign load_en   = !handshake_valid || handshake_ready;

  // The search order starts at ptr. The grant value is ignored when no channel is valid.
  always_comb begin
    grant = 2'd0;
    case (ptr)
      2'd1: begin
        if (in_valid[1])      grant = 2'd1;
        else if (in_valid[2]) grant = 2'd2;
        else                  grant = 2'd0;
      end
      2'd2: begin
        if (in_valid[2])      grant = 2'd2;
        else if (in_valid[0]) grant = 2'd0;
        else                  grant = 2'd1;
      end
      default: begin
        if (in_valid[0])      grant = 2'd0;
        else if (in_valid[1]) grant = 2'd1;
        else                  grant = 2'd2;
      end
    endcase
  end

  always_comb begin
    ptr_next   = 2'd0;
    grant_data = data_0;
    case (grant)
      2'd1: begin
        ptr_next   = 2'd2;
        grant_data = data_1;
      end
      2'd2: begin
        ptr_next   = 2'd0;
        grant_data = data_2;
      end
      default: begin
        ptr_next   = 2'd1;
        grant_data = data_0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ready
      assign in_ready[gi] = RESETN && load_en && any_valid && (grant == gi[1:0]);
    end
  endgenerate

  assign handshake_arr_0_ready = in_ready[0];
  assign handshake_arr_1_ready = in_ready[1];
  assign handshake_arr_2_ready = in_ready[2];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      handshake_valid <= 1'b0;
      out_data        <= '0;
      out_src         <= 2'd0;
      ptr             <= 2'd0;
      xfer_count      <= '0;
    end else begin
      if (handshake_valid && handshake_ready)
        xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (load_en) begin
        if (any_valid) begin
          handshake_valid <= 1'b1;
          out_data        <= grant_data;
          out_src         <= grant;
          ptr             <= ptr_next;
        end else begin
          handshake_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_handshake_rr_merge.sv
// Directed bench for handshake_rr_merge.
// The expected values are worked out by hand for each step of the input sequence.
module tb_handshake_rr_merge;

  logic       clk = 1'b0;
  logic       resetn;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic [4:0] d0, d1, d2;
  logic       hv, hr;
  logic [4:0] od;
  logic [1:0] os;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  handshake_rr_merge #(.WIDTH(5), .CNT_WIDTH(8)) dut (
    .CLK(clk),
    .RESETN(resetn),
    .handshake_arr_0_valid(v0),
    .handshake_arr_0_ready(r0),
    .data_0(d0),
    .handshake_arr_1_valid(v1),
    .handshake_arr_1_ready(r1),
    .data_1(d1),
    .handshake_arr_2_valid(v2),
    .handshake_arr_2_ready(r2),
    .data_2(d2),
    .handshake_valid(hv),
    .handshake_ready(hr),
    .out_data(od),
    .out_src(os),
    .xfer_count(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; hr = 1'b1;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    d0 = 5'h01; d1 = 5'h02; d2 = 5'h03;

    // Reset held for three cycles while all channels are valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_readies", {29'd0, r2, r1, r0}, 32'd0);
      chk("rst_hv", hv, 1'b0);
      chk("rst_cnt", cnt, 8'd0);
    end

    // After reset is released, the first grant goes to channel 0.
    resetn = 1'b1;
    #1;
    chk("first_grant", {29'd0, r2, r1, r0}, 32'b001);

    // All three channels contend for six cycles.
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("contention beat %0d: src=%0d data=%0h cnt=%0d", i, os, od, cnt);
      chk("cont_hv", hv, 1'b1);
      chk("cont_src", os, i % 3);
      chk("cont_data", od, (i % 3) + 1);
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    tick();
    chk("cont_cnt", cnt, 8'd6);
    chk("cont_drain_hv", hv, 1'b0);

    // Backpressure: a beat from channel 1 is held while the output is stalled.
    v1 = 1'b1; d1 = 5'h1A;
    #1;
    chk("bp_grant1", {29'd0, r2, r1, r0}, 32'b010);
    tick();
    v1 = 1'b0; hr = 1'b0;
    v0 = 1'b1; d0 = 5'h0C;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_readies", {29'd0, r2, r1, r0}, 32'd0);
      chk("bp_data", od, 5'h1A);
      chk("bp_src", os, 2'd1);
      chk("bp_hv", hv, 1'b1);
      chk("bp_cnt", cnt, 8'd6);
      tick();
    end
    hr = 1'b1;
    #1;
    chk("bp_release_ready", {29'd0, r2, r1, r0}, 32'b001);
    tick();
    $display("backpressure release: src=%0d data=%0h cnt=%0d", os, od, cnt);
    chk("bp_cnt7", cnt, 8'd7);
    chk("bp_next_data", od, 5'h0C);
    chk("bp_next_src", os, 2'd0);
    v0 = 1'b0;
    tick();
    chk("bp_cnt8", cnt, 8'd8);
    chk("bp_empty", hv, 1'b0);

    // Sparse traffic: only channel 2 sends, once every three cycles.
    for (int j = 0; j < 3; j++) begin
      v2 = 1'b1; d2 = 5'h15 + 5'(j);
      #1;
      chk("sp_ready2", {29'd0, r2, r1, r0}, 32'b100);
      tick();
      v2 = 1'b0;
      $display("sparse beat %0d: src=%0d data=%0h", j, os, od);
      chk("sp_hv", hv, 1'b1);
      chk("sp_src", os, 2'd2);
      chk("sp_data", od, 32'h15 + j);
      tick();
      chk("sp_idle1", hv, 1'b0);
      tick();
      chk("sp_idle2", hv, 1'b0);
    end
    chk("sp_cnt", cnt, 8'd11);

    // Reset mid-stream while a beat is stalled at the output.
    hr = 1'b0; v0 = 1'b1; d0 = 5'h07;
    tick();
    v0 = 1'b0;
    chk("mr_loaded", hv, 1'b1);
    resetn = 1'b0;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    #1;
    chk("mr_readies", {29'd0, r2, r1, r0}, 32'd0);
    tick();
    chk("mr_hv", hv, 1'b0);
    chk("mr_data", od, 5'h00);
    chk("mr_src", os, 2'd0);
    chk("mr_cnt", cnt, 8'd0);
    resetn = 1'b1;
    #1;
    chk("mr_ptr0", {29'd0, r2, r1, r0}, 32'b001);

    // Counter wrap: 257 output handshakes bring the count back to 1.
    hr = 1'b1;
    d0 = 5'h01; d1 = 5'h02; d2 = 5'h03;
    for (int k = 1; k <= 258; k++) begin
      tick();
      if (k == 256) chk("wrap_255", cnt, 8'd255);
      if (k == 257) chk("wrap_0", cnt, 8'd0);
    end
    $display("wrap: cnt=%0d", cnt);
    chk("wrap_1", cnt, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_rr_merge.md
# handshake_rr_merge

Three-to-one round-robin merge stage feeding the `RTL_unq1` datapath. It accepts three independent ready/valid producer channels, `handshake_arr_0..2`, each carrying a `WIDTH`-bit payload. It presents one registered ready/valid stream on the `handshake` / `in1` port pair of the downstream block, and tags each beat with its source index. A wrapping beat counter is exposed for bind-style monitors.

## Interface
- `WIDTH`, default 5: payload width; matches the downstream `in1` width.
- `CNT_WIDTH`, default 8: width of the transfer counter.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESETN`  in  1  synchronous, active-low reset, sampled on the `CLK` rising edge.
- `handshake_arr_k_valid`  in  1  producer k has a beat (k = 0, 1, 2).
- `handshake_arr_k_ready`  out  1  merge accepts the beat from producer k this cycle.
- `data_k`  in  WIDTH  payload of producer k.
- `handshake_valid`  out  1  registered output beat valid.
- `handshake_ready`  in  1  downstream accepts the output beat.
- `out_data`  out  WIDTH  registered output payload (drives `in1`).
- `out_src`  out  2  index (0..2) of the producer that supplied `out_data`.
- `xfer_count`  out  CNT_WIDTH  count of completed output handshakes.

## Operation
- The output register holds one beat: `handshake_valid`, `out_data`, `out_src`.
- `load_en = !handshake_valid || handshake_ready`. The register may take a new beat only when it is empty or is draining this cycle.
- Round-robin pointer `ptr` ranges over 0..2. The grant goes to the first k with `handshake_arr_k_valid` high, searching k = ptr, ptr+1, ptr+2 (mod 3).
- `handshake_arr_k_ready = RESETN && load_en && (grant == k) && any_valid`. At most one ready is high per cycle.
  - Ready depends combinationally on `handshake_ready` and the input valids.
  - Valid never depends on ready.
- On an accepted input beat (`valid && ready` on channel g):
  - `out_data <= data_g`, `out_src <= g`, `handshake_valid <= 1`;
  - `ptr <= (g+1) mod 3`.
- If `load_en` is true and no input is valid, `handshake_valid <= 0`. `out_data` and `out_src` hold their old values, which are don't-care.
- If `load_en` is false, the register, `ptr` and all input readies hold. The output beat stays stable until accepted; no payload change occurs while valid and not ready.
- `ptr` does not advance when there is no grant.
- `xfer_count` increments by 1 on every `handshake_valid && handshake_ready`, and wraps from 2^CNT_WIDTH−1 to 0.
- Producer-side rule: a producer must hold its valid and data until it sees ready. The merge does not check this.

## Timing
- Reset (`RESETN` low at a rising edge): `handshake_valid=0`, `out_data=0`, `out_src=0`, `ptr=0`, `xfer_count=0`.
  - All `handshake_arr_k_ready` are 0 combinationally while `RESETN` is low.
  - Reset mid-operation discards any held beat. No input handshake completes in a reset cycle.
- Latency: an input beat accepted at edge n appears on `handshake_valid` / `out_data` after edge n, i.e. a 1-cycle latency.
- Throughput: 1 beat/cycle with `handshake_ready` held high. Output drain and input load happen in the same cycle.
- Backpressure: when `handshake_ready` is low and the register is full, all input readies are 0 that cycle.
- Fairness: with all three channels continuously valid and the output always ready, grants repeat 0, 1, 2, 0, … Each channel is granted within 3 accepted beats of asserting valid.
- Simultaneous events:
  - A drain and a load in the same cycle give a count +1 and a new beat.
  - The count wrap and a new handshake in the same cycle follow normal wrap behaviour.

## Test plan
- **Reset:** hold `RESETN=0` 3 cycles with all inputs valid → all readies 0, `handshake_valid=0`, `xfer_count=0`. After release, the first grant goes to channel 0.
- **Full contention:**
  - Stimulus: all channels valid continuously, with data_0=5'h01, data_1=5'h02, data_2=5'h03; `handshake_ready=1` for 6 cycles.
  - Required response: `out_src` sequence 0,1,2,0,1,2 with matching data, and `xfer_count=6`.
- **Backpressure:**
  - Stimulus: a beat from channel 1 (data 5'h1A) is loaded, then `handshake_ready=0` for 4 cycles.
  - Required response: `out_data` stable at 5'h1A, all readies 0, no count change. The next cycle with ready high completes the transfer and loads the next beat.
- **Sparse traffic:** only channel 2 valid, once every 3 cycles, with `handshake_ready=1` → every beat has `out_src=2` with 1-cycle latency. `handshake_valid` falls in the idle cycles.
- **Counter wrap:** with CNT_WIDTH=8, drive 257 output handshakes → `xfer_count=1`.
- **Reset mid-stream:**
  - Stimulus: assert `RESETN=0` for one cycle while `handshake_valid=1` and `handshake_ready=0`.
  - Required response: the beat is dropped, outputs return to reset values, and `ptr` restarts at 0.
